// File: rtl/bht_local_history.sv
// Per-branch local history table: DEPTH entries of HIST_W-bit taken/not-taken
// history with speculative shift, whole-entry repair and a sequenced clear sweep.
module bht_local_history #(
   parameter int DEPTH  = 16,
   parameter int HIST_W = 5,
   parameter int IDX_W  = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              rd_en,
   input  logic [IDX_W-1:0]  rd_idx,
   output logic [HIST_W-1:0] rd_hist,
   input  logic              upd_en,
   input  logic [IDX_W-1:0]  upd_idx,
   input  logic              upd_taken,
   input  logic              fix_en,
   input  logic [IDX_W-1:0]  fix_idx,
   input  logic [HIST_W-1:0] fix_hist,
   input  logic              clr_req,
   output logic              busy
);

   typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [IDX_W-1:0]   r_clr_ptr;
   logic [IDX_W-1:0]   w_clr_ptr_nxt;
   logic [HIST_W-1:0]  r_hist [DEPTH];
   logic [HIST_W-1:0]  w_shifted;
   logic               w_upd_go;
   logic               w_fix_go;

   // A one-bit history simply becomes the latest outcome.
   generate
      if (HIST_W == 1) begin : g_hist_w1
         assign w_shifted = upd_taken;
      end else begin : g_hist_wn
         assign w_shifted = {r_hist[upd_idx][HIST_W-2:0], upd_taken};
      end
   endgenerate

   assign busy     = (r_state == ST_CLEAR);
   assign w_fix_go = fix_en && !busy;
   assign w_upd_go = upd_en && !busy && !(fix_en && (fix_idx == upd_idx));
   assign rd_hist  = (rd_en && !busy) ? r_hist[rd_idx] : '0;

   always_comb begin
      w_state_nxt   = r_state;
      w_clr_ptr_nxt = r_clr_ptr;
      case (r_state)
         ST_IDLE: begin
            if (clr_req) begin
               w_state_nxt   = ST_CLEAR;
               w_clr_ptr_nxt = '0;
            end
         end
         ST_CLEAR: begin
            w_clr_ptr_nxt = r_clr_ptr + 1'b1;
            if (r_clr_ptr == IDX_W'(DEPTH - 1)) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt   = ST_IDLE;
            w_clr_ptr_nxt = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_clr_ptr <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_clr_ptr <= w_clr_ptr_nxt;
      end
   end

   // Sweep owns the table while busy; otherwise a fix overrides a same-index update.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_hist[i] <= '0;
         end
      end else if (busy) begin
         r_hist[r_clr_ptr] <= '0;
      end else begin
         if (w_upd_go) begin
            r_hist[upd_idx] <= w_shifted;
         end
         if (w_fix_go) begin
            r_hist[fix_idx] <= fix_hist;
         end
      end
   end

endmodule
